// File: rtl/serial_shifter_pkg.sv
// Shared constants for the iterative shifter.
// Op codes, FSM state encodings and the fill bit.
package serial_shifter_pkg;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b01;
    localparam logic [1:0] SHIFT_SRA = 2'b11;

    localparam logic ZERO = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/shift_left_1bit.sv
// Single-bit logical left shift stage.
// Purely combinational; fills the LSB with zero.
module shift_left_1bit
    import serial_shifter_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] d,
    output logic [n-1:0] q
);

    assign q = {d[n-2:0], ZERO};

endmodule

// File: rtl/shift_right_1bit.sv
// Single-bit right shift stage.
// arith selects sign fill (SRA) versus zero fill (SRL).
module shift_right_1bit
    import serial_shifter_pkg::*;
#(
    parameter int n = 32
) (
    input  logic [n-1:0] d,
    input  logic         arith,
    output logic [n-1:0] q
);

    assign q = {(arith ? d[n-1] : ZERO), d[n-1:1]};

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle shifter for SLL/SRL/SRA: one bit per clock.
// busy stalls the pipeline; done pulses for one cycle with result.
module serial_shifter
    import serial_shifter_pkg::*;
#(
    parameter int N       = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N-1:0]       a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic               busy,
    output logic               done,
    output logic [N-1:0]       result
);

    state_t             state;
    logic [N-1:0]       sr;
    logic [SHAMT_W-1:0] cnt;
    logic [1:0]         op_r;

    logic [N-1:0]       sl_out;
    logic [N-1:0]       sr_out;
    logic [N-1:0]       next_sr;

    shift_left_1bit #(.n(N)) u_sll (
        .d (sr),
        .q (sl_out)
    );

    shift_right_1bit #(.n(N)) u_srx (
        .d     (sr),
        .arith (op_r[1]),
        .q     (sr_out)
    );

    // Reserved op keeps the value but still burns the same cycles.
    always_comb begin
        next_sr = sr;
        case (op_r)
            SHIFT_SLL: next_sr = sl_out;
            SHIFT_SRL: next_sr = sr_out;
            SHIFT_SRA: next_sr = sr_out;
            default:   next_sr = sr;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            sr     <= '0;
            cnt    <= '0;
            op_r   <= SHIFT_SLL;
            result <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sr   <= a;
                        cnt  <= shamt;
                        op_r <= op;
                        if (shamt == '0) begin
                            state  <= DONE;
                            result <= a;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    sr  <= next_sr;
                    cnt <= cnt - SHAMT_W'(1);
                    if (cnt == SHAMT_W'(1)) begin
                        state  <= DONE;
                        result <= next_sr;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: doc/serial_shifter.md
Name: serial_shifter

Overview:
- Multi-cycle iterative shifter for the ALU shift instructions (SLL, SRL, SRA, plus immediate forms).
- Shifts the operand one bit per clock, reusing single-bit shift stages instead of a full barrel shifter.
- Sits beside the ALU in the execute stage; the control unit stalls the pipeline while busy is high.
- Operands come from the register file or immediate mux; the result goes to the writeback mux.

Parameters:
- N, 32, operand/result width.
- SHAMT_W, 5, shift-amount width; must equal clog2(N).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a shift; sampled on rising clk edge.
- a  input  N  operand to shift.
- shamt  input  SHAMT_W  shift amount, 0..N-1.
- op  input  2  shift type: 00 SLL, 01 SRL, 11 SRA, 10 reserved.
- busy  output  1  high while shifting; the pipeline must stall.
- done  output  1  one-cycle pulse: result valid.
- result  output  N  shifted value; held until the next accepted start.

Behaviour:
- Reset (async, rst=1): state=IDLE, busy=0, done=0, result=0, internal shift reg=0, counter=0. Outputs take effect immediately, without waiting for clk. Deasserting rst mid-operation gives no partial result; the block is idle.
- States: IDLE, SHIFT, DONE.
- Start is accepted on an edge where start=1 and state is IDLE or DONE, so back-to-back operations are allowed. Start while in SHIFT is ignored and not queued.
- On an accepted start at edge k:
  - latch a into the shift reg, shamt into the counter, op into the op reg;
  - shamt=0 -> DONE;
  - shamt>0 -> SHIFT.
- SHIFT, each edge:
  - SLL: shift reg <= {sr[N-2:0],0}.
  - SRL: shift reg <= {0,sr[N-1:1]}.
  - SRA: shift reg <= {sr[N-1],sr[N-1:1]}.
  - op=10: shift reg unchanged; the counter still runs, so timing is identical.
  - Counter decrements. When the counter is 1 at an edge, the final shift happens and the next state is DONE.
- Entering DONE: result <= final shift reg value, loaded on the same edge as the transition.
- DONE lasts exactly one cycle:
  - done=1, busy=0;
  - next state is IDLE, or SHIFT/DONE if start=1.
- Latency: done is high in the cycle after edge k+shamt (shamt=0 -> cycle after edge k). Total cycles from the start edge is shamt+1.
- busy = (state==SHIFT), combinational from the state reg. done = (state==DONE).
- result changes only on entry to DONE; it is stable in IDLE and SHIFT.
- Inputs a, shamt and op are don't-care after the accepting edge.
- shamt is interpreted as unsigned; wider amounts are already masked upstream.

Decomposition:
- Shared defines file:
  - shift op codes (SHIFT_SLL=2'b00, SHIFT_SRL=2'b01, SHIFT_SRA=2'b11);
  - FSM state encodings (IDLE=2'b00, SHIFT=2'b01, DONE=2'b10);
  - the ZERO bit constant.
- One combinational sub-module, shift_right_1bit (parameter n): single-bit logical/arithmetic right shift selected by an arith input.
- The existing single-bit left-shift stage is instantiated for the SLL path.
- The FSM, counter and result register stay in serial_shifter.

Test Plan:
- Reset mid-operation: start a=32'hFFFF_0000, shamt=20, SLL; assert rst at cycle 5 -> busy=0, done=0, result=0 immediately; next start behaves normally.
- shamt=0: start a=32'h1234_5678, SLL -> busy never high; done=1 in the cycle after the start edge; result=32'h1234_5678.
- SLL: a=32'h0000_0001, shamt=31 -> busy high 31 cycles; done in cycle 32 after start; result=32'h8000_0000.
- SRL/SRA:
  - a=32'h8000_00F0, shamt=4, SRL -> result=32'h0800_000F after 5 cycles;
  - same inputs with SRA -> result=32'hF800_000F.
- Start ignored while busy: start SLL a=1, shamt=3, then pulse start with a=7, shamt=1 during SHIFT -> result=32'h8; the second request is not executed.
- Back-to-back: assert start in the DONE cycle with a=32'hF, SRL, shamt=2 -> first result held; next done 3 cycles later with result=32'h3; busy has no gap beyond DONE.
